fifo_rr_scheduler: RTL and testbench

//  Round-robin egress scheduler for four fifo_6x8 ingress queues (one per lane/VC) feeding one downstream fifo_6x8.

---
 rtl/fifo_rr_scheduler_if.sv | 34 +++
 rtl/fifo_rr_scheduler.sv | 143 ++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_scheduler_if.sv
// Handshake bundle between the round-robin scheduler, its four ingress FIFOs
// and the egress FIFO. The scheduler uses the slave modport; its environment uses master.
interface fifo_rr_scheduler_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_IN    = 4
);
    logic                        enable;
    logic                        init;
    logic [2:0]                  burst_max;
    logic [NUM_IN-1:0]           in_empty;
    logic [NUM_IN-1:0]           in_almost_empty;
    logic [NUM_IN-1:0]           in_error;
    logic [NUM_IN*DATA_SIZE-1:0] in_data;
    logic                        out_pause;
    logic                        out_almost_full;
    logic [NUM_IN-1:0]           in_read;
    logic                        out_write;
    logic [DATA_SIZE-1:0]        out_data;
    logic [1:0]                  grant_id;
    logic [2:0]                  sched_state;
    logic                        error_out;

    modport master (
        output enable, init, burst_max, in_empty, in_almost_empty, in_error, in_data,
               out_pause, out_almost_full,
        input  in_read, out_write, out_data, grant_id, sched_state, error_out
    );

    modport slave (
        input  enable, init, burst_max, in_empty, in_almost_empty, in_error, in_data,
               out_pause, out_almost_full,
        output in_read, out_write, out_data, grant_id, sched_state, error_out
    );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin egress scheduler: pops four ingress FIFOs in bursts and forwards the
// popped bytes to one egress FIFO through a two-stage read->write pipeline.
module fifo_rr_scheduler #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_IN    = 4
) (
    input logic           clk,
    input logic           reset,
    fifo_rr_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2:0]           burst_lim;
    logic [2:0]           eff_max;
    logic [2:0]           count;
    logic [2:0]           count_inc;
    logic [2:0]           count_next;
    logic [1:0]           grant;
    logic [1:0]           grant_next;
    logic [1:0]           search_grant;
    logic [1:0]           idx;
    logic [1:0]           read_tag;
    logic [1:0]           s1_tag;
    logic                 found;
    logic                 any_error;
    logic                 blocked;
    logic                 hazard;
    logic                 issue;
    logic                 rotate;
    logic [NUM_IN-1:0]    read_q;
    logic [NUM_IN-1:0]    read_next;
    logic                 s1_valid;
    logic                 write_q;
    logic                 error_q;
    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] popped;

    assign any_error = |bus.in_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Error detection overrides every other transition; ERROR is left only by reset.
    always_comb begin
        state_next = state;
        if (any_error) begin
            state_next = ST_ERROR;
        end else begin
            case (state)
                ST_INIT:   if (bus.init) state_next = ST_IDLE;
                ST_IDLE:   if (bus.enable && !(&bus.in_empty)) state_next = ST_ACTIVE;
                ST_ACTIVE: if (!bus.enable || (&bus.in_empty)) state_next = ST_DRAIN;
                ST_DRAIN:  if (read_q == '0 && !s1_valid) state_next = ST_IDLE;
                ST_ERROR:  state_next = ST_ERROR;
                default:   state_next = ST_INIT;
            endcase
        end
    end

    // A queue showing almost_empty while being popped may hold only that entry,
    // so a second back-to-back pop is held off for one cycle.
    always_comb begin
        eff_max      = (burst_lim == 3'd0) ? 3'd1 : burst_lim;
        count_inc    = count + 3'd1;
        blocked      = bus.out_pause | bus.out_almost_full;
        hazard       = read_q[grant] & bus.in_almost_empty[grant];
        issue        = (state == ST_ACTIVE) & bus.enable & ~any_error & ~bus.in_empty[grant]
                       & ~blocked & ~hazard;
        search_grant = grant;
        found        = 1'b0;
        idx          = grant;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = grant + 2'(k);
            if (!found && !bus.in_empty[idx]) begin
                search_grant = idx;
                found        = 1'b1;
            end
        end
        rotate = 1'b0;
        if (state == ST_ACTIVE && !any_error) begin
            rotate = issue ? (count_inc == eff_max) : bus.in_empty[grant];
        end
        grant_next = rotate ? search_grant : grant;
        count_next = rotate ? 3'd0 : (issue ? count_inc : count);
        read_next  = issue ? ({{(NUM_IN-1){1'b0}}, 1'b1} << grant) : '0;
    end

    always_comb begin
        read_tag = '0;
        popped   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (read_q[i]) read_tag = 2'(i);
            if (s1_tag == 2'(i)) popped = bus.in_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Pipeline stages keep running in DRAIN and ERROR so already-popped bytes reach the egress FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_lim <= '0;
            grant     <= '0;
            count     <= '0;
            read_q    <= '0;
            s1_valid  <= 1'b0;
            s1_tag    <= '0;
            write_q   <= 1'b0;
            data_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            if (state == ST_INIT && bus.init) burst_lim <= bus.burst_max;
            grant    <= grant_next;
            count    <= count_next;
            read_q   <= read_next;
            s1_valid <= |read_q;
            s1_tag   <= read_tag;
            write_q  <= s1_valid;
            if (s1_valid) data_q <= popped;
            error_q  <= error_q | any_error;
        end
    end

    assign bus.in_read     = read_q;
    assign bus.out_write   = write_q;
    assign bus.out_data    = data_q;
    assign bus.grant_id    = grant;
    assign bus.sched_state = state;
    assign bus.error_out   = error_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler; four small behavioural ingress FIFOs
// supply empty/almost_empty flags and registered pop data.
module tb_fifo_rr_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_rr_scheduler_if #(.DATA_SIZE(8), .NUM_IN(4)) bus ();

    fifo_rr_scheduler #(.DATA_SIZE(8), .NUM_IN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0] q_mem [4][8];
    int         q_wp  [4];
    int         q_rp  [4];
    int         q_cnt [4];
    logic [7:0] q_out [4];
    logic       underflow;
    logic       push_en;
    logic       model_clear;
    int         push_sel;
    logic [7:0] push_val;
    logic       pop_now;
    logic       push_now;

    // Ingress FIFO models: pops read out one cycle later, pushes come from the loader task.
    always @(posedge clk) begin
        if (model_clear) begin
            for (int i = 0; i < 4; i++) begin
                q_wp[i]  <= 0;
                q_rp[i]  <= 0;
                q_cnt[i] <= 0;
                q_out[i] <= 8'h00;
            end
            underflow <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pop_now  = bus.in_read[i] && (q_cnt[i] > 0);
                push_now = push_en && (push_sel == i);
                if (bus.in_read[i] && q_cnt[i] == 0) underflow <= 1'b1;
                if (pop_now) begin
                    q_out[i] <= q_mem[i][q_rp[i]];
                    q_rp[i]  <= (q_rp[i] + 1) % 8;
                end
                if (push_now) begin
                    q_mem[i][q_wp[i]] <= push_val;
                    q_wp[i]           <= (q_wp[i] + 1) % 8;
                end
                q_cnt[i] <= q_cnt[i] + (push_now ? 1 : 0) - (pop_now ? 1 : 0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.in_empty[i]        = (q_cnt[i] == 0);
            bus.in_almost_empty[i] = (q_cnt[i] <= 1);
            bus.in_data[i*8 +: 8]  = q_out[i];
        end
    end

    task automatic do_reset();
        reset               = 1'b1;
        model_clear         = 1'b1;
        push_en             = 1'b0;
        push_sel            = 0;
        push_val            = 8'h00;
        bus.enable          = 1'b0;
        bus.init            = 1'b0;
        bus.burst_max       = 3'd0;
        bus.in_error        = 4'b0000;
        bus.out_pause       = 1'b0;
        bus.out_almost_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        model_clear = 1'b0;
    endtask

    task automatic start_sched(input logic [2:0] bmax);
        bus.burst_max = bmax;
        bus.init      = 1'b1;
        @(negedge clk);
        bus.init      = 1'b0;
    endtask

    task automatic load_queue(input int q, input logic [7:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            push_sel = q;
            push_val = base + 8'(j);
            push_en  = 1'b1;
            @(negedge clk);
        end
        push_en = 1'b0;
    endtask

    task automatic wait_first_read(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_read != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wait_first_read: in_read=%b after 20 cycles, required a read", bus.in_read);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL rst_in_read: got %b expected 0000", bus.in_read); end
        checks++; if (bus.out_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_write: got %b expected 0", bus.out_write); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_out_data: got %h expected 00", bus.out_data); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL rst_grant: got %0d expected 0", bus.grant_id); end
        checks++; if (bus.sched_state !== 3'd0) begin errors++; $display("[TB] FAIL rst_state: got %0d expected 0", bus.sched_state); end
        checks++; if (bus.error_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: got %b expected 0", bus.error_out); end
        bus.enable = 1'b1;
        load_queue(0, 8'h11, 1);
        @(negedge clk);
        checks++; if (bus.sched_state !== 3'd0) begin errors++; $display("[TB] FAIL rst_hold_init: got %0d expected 0", bus.sched_state); end
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL rst_no_read_in_init: got %b expected 0000", bus.in_read); end
        bus.enable = 1'b0;
        start_sched(3'd1);
        checks++; if (bus.sched_state !== 3'd1) begin errors++; $display("[TB] FAIL rst_init_to_idle: got %0d expected 1", bus.sched_state); end
    endtask

    task automatic test_single_queue_burst();
        logic [3:0] rd [8];
        logic       wr [8];
        logic [7:0] wd [8];
        logic [1:0] gn [8];
        logic [2:0] st [8];
        logic       ok;
        logic [3:0] exp_rd;
        logic       exp_wr;
        do_reset();
        start_sched(3'd2);
        load_queue(0, 8'hA0, 4);
        bus.enable = 1'b1;
        @(negedge clk);
        wait_first_read(ok);
        for (int k = 0; k < 8; k++) begin
            rd[k] = bus.in_read;
            wr[k] = bus.out_write;
            wd[k] = bus.out_data;
            gn[k] = bus.grant_id;
            st[k] = bus.sched_state;
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            exp_rd = (k < 4) ? 4'b0001 : 4'b0000;
            checks++; if (rd[k] !== exp_rd) begin errors++; $display("[TB] FAIL burst_read[%0d]: got %b expected %b", k, rd[k], exp_rd); end
        end
        for (int k = 0; k < 7; k++) begin
            exp_wr = (k >= 2 && k <= 5);
            checks++; if (wr[k] !== exp_wr) begin errors++; $display("[TB] FAIL burst_write[%0d]: got %b expected %b", k, wr[k], exp_wr); end
            if (exp_wr) begin
                checks++; if (wd[k] !== 8'hA0 + 8'(k - 2)) begin errors++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", k, wd[k], 8'hA0 + 8'(k - 2)); end
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (gn[k] !== 2'd0) begin errors++; $display("[TB] FAIL burst_grant[%0d]: got %0d expected 0", k, gn[k]); end
        end
        checks++; if (st[5] !== 3'd3) begin errors++; $display("[TB] FAIL burst_drain: got %0d expected 3", st[5]); end
        checks++; if (st[6] !== 3'd1) begin errors++; $display("[TB] FAIL burst_idle: got %0d expected 1", st[6]); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL burst_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_round_robin();
        logic [7:0] got     [16];
        int         got_cyc [16];
        int         n;
        logic [7:0] exp_b;
        do_reset();
        start_sched(3'd1);
        for (int q = 0; q < 4; q++) load_queue(q, 8'((q + 1) * 16), 3);
        bus.enable = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.out_write) begin
                if (n < 16) begin
                    got[n]     = bus.out_data;
                    got_cyc[n] = cyc;
                end
                n++;
            end
        end
        checks++; if (n !== 12) begin errors++; $display("[TB] FAIL rr_count: got %0d writes expected 12", n); end
        for (int i = 0; i < 12; i++) begin
            exp_b = 8'((i % 4 + 1) * 16 + i / 4);
            checks++; if (i >= n || got[i] !== exp_b) begin errors++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", i, got[i], exp_b); end
        end
        checks++; if (n < 12 || got_cyc[11] - got_cyc[0] !== 11) begin errors++; $display("[TB] FAIL rr_no_bubble: span %0d cycles expected 11", got_cyc[11] - got_cyc[0]); end
    endtask

    task automatic test_burst_zero();
        logic [7:0] got [8];
        logic [7:0] exp_seq [6];
        int         n;
        exp_seq = '{8'h70, 8'h80, 8'h71, 8'h81, 8'h72, 8'h82};
        do_reset();
        start_sched(3'd0);
        load_queue(0, 8'h70, 3);
        load_queue(1, 8'h80, 3);
        bus.enable = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (bus.out_write) begin
                if (n < 8) got[n] = bus.out_data;
                n++;
            end
        end
        checks++; if (n !== 6) begin errors++; $display("[TB] FAIL bz_count: got %0d writes expected 6", n); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (i >= n || got[i] !== exp_seq[i]) begin errors++; $display("[TB] FAIL bz_data[%0d]: got %h expected %h", i, got[i], exp_seq[i]); end
        end
    endtask

    task automatic test_single_entry();
        int         reads2;
        int         reads_other;
        int         n;
        logic [7:0] wbyte;
        do_reset();
        start_sched(3'd4);
        load_queue(2, 8'h5A, 1);
        bus.enable  = 1'b1;
        reads2      = 0;
        reads_other = 0;
        n           = 0;
        wbyte       = 8'h00;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.in_read[2]) reads2++;
            if (bus.in_read[0] || bus.in_read[1] || bus.in_read[3]) reads_other++;
            if (bus.out_write) begin
                n++;
                wbyte = bus.out_data;
            end
        end
        checks++; if (reads2 !== 1) begin errors++; $display("[TB] FAIL se_reads_q2: got %0d expected 1", reads2); end
        checks++; if (reads_other !== 0) begin errors++; $display("[TB] FAIL se_reads_other: got %0d expected 0", reads_other); end
        checks++; if (n !== 1) begin errors++; $display("[TB] FAIL se_writes: got %0d expected 1", n); end
        checks++; if (wbyte !== 8'h5A) begin errors++; $display("[TB] FAIL se_data: got %h expected 5a", wbyte); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL se_underflow: got %b expected 0", underflow); end
        checks++; if (bus.error_out !== 1'b0) begin errors++; $display("[TB] FAIL se_error: got %b expected 0", bus.error_out); end
        checks++; if (bus.sched_state !== 3'd1) begin errors++; $display("[TB] FAIL se_state: got %0d expected 1", bus.sched_state); end
        checks++; if (bus.grant_id !== 2'd2) begin errors++; $display("[TB] FAIL se_grant: got %0d expected 2", bus.grant_id); end
    endtask

    task automatic test_backpressure();
        logic ok;
        do_reset();
        start_sched(3'd3);
        load_queue(0, 8'h30, 4);
        load_queue(1, 8'h40, 2);
        bus.enable = 1'b1;
        @(negedge clk);
        wait_first_read(ok);
        checks++; if (bus.in_read !== 4'b0001) begin errors++; $display("[TB] FAIL bp_first: got %b expected 0001", bus.in_read); end
        @(negedge clk);
        checks++; if (bus.in_read !== 4'b0001) begin errors++; $display("[TB] FAIL bp_second: got %b expected 0001", bus.in_read); end
        bus.out_pause = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL bp_hold1: got %b expected 0000", bus.in_read); end
        checks++; if (bus.out_write !== 1'b1 || bus.out_data !== 8'h30) begin errors++; $display("[TB] FAIL bp_flight1: got %b/%h expected 1/30", bus.out_write, bus.out_data); end
        @(negedge clk);
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL bp_hold2: got %b expected 0000", bus.in_read); end
        checks++; if (bus.out_write !== 1'b1 || bus.out_data !== 8'h31) begin errors++; $display("[TB] FAIL bp_flight2: got %b/%h expected 1/31", bus.out_write, bus.out_data); end
        @(negedge clk);
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL bp_hold3: got %b expected 0000", bus.in_read); end
        checks++; if (bus.out_write !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle_write: got %b expected 0", bus.out_write); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL bp_grant_held: got %0d expected 0", bus.grant_id); end
        bus.out_pause = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_read !== 4'b0001) begin errors++; $display("[TB] FAIL bp_resume: got %b expected 0001", bus.in_read); end
        checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("[TB] FAIL bp_rotate: got %0d expected 1", bus.grant_id); end
        @(negedge clk);
        checks++; if (bus.in_read !== 4'b0010) begin errors++; $display("[TB] FAIL bp_next_queue: got %b expected 0010", bus.in_read); end
    endtask

    task automatic test_error();
        logic ok;
        do_reset();
        start_sched(3'd4);
        load_queue(0, 8'h50, 4);
        bus.enable = 1'b1;
        @(negedge clk);
        wait_first_read(ok);
        bus.in_error = 4'b0010;
        @(negedge clk);
        bus.in_error = 4'b0000;
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL err_read_cut: got %b expected 0000", bus.in_read); end
        checks++; if (bus.sched_state !== 3'd4) begin errors++; $display("[TB] FAIL err_state: got %0d expected 4", bus.sched_state); end
        checks++; if (bus.error_out !== 1'b1) begin errors++; $display("[TB] FAIL err_flag: got %b expected 1", bus.error_out); end
        @(negedge clk);
        checks++; if (bus.out_write !== 1'b1 || bus.out_data !== 8'h50) begin errors++; $display("[TB] FAIL err_flight: got %b/%h expected 1/50", bus.out_write, bus.out_data); end
        repeat (3) @(negedge clk);
        checks++; if (bus.error_out !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", bus.error_out); end
        checks++; if (bus.sched_state !== 3'd4) begin errors++; $display("[TB] FAIL err_stay: got %0d expected 4", bus.sched_state); end
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL err_no_read: got %b expected 0000", bus.in_read); end
        do_reset();
        checks++; if (bus.error_out !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", bus.error_out); end
        checks++; if (bus.sched_state !== 3'd0) begin errors++; $display("[TB] FAIL err_reset_state: got %0d expected 0", bus.sched_state); end
    endtask

    task automatic test_reset_mid_burst();
        logic ok;
        int   late_writes;
        do_reset();
        start_sched(3'd4);
        load_queue(0, 8'h60, 4);
        bus.enable = 1'b1;
        @(negedge clk);
        wait_first_read(ok);
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.out_write !== 1'b1 || bus.out_data !== 8'h60) begin errors++; $display("[TB] FAIL rmb_pre: got %b/%h expected 1/60", bus.out_write, bus.out_data); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.in_read !== 4'b0000) begin errors++; $display("[TB] FAIL rmb_in_read: got %b expected 0000", bus.in_read); end
        checks++; if (bus.out_write !== 1'b0) begin errors++; $display("[TB] FAIL rmb_out_write: got %b expected 0", bus.out_write); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("[TB] FAIL rmb_out_data: got %h expected 00", bus.out_data); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("[TB] FAIL rmb_grant: got %0d expected 0", bus.grant_id); end
        checks++; if (bus.sched_state !== 3'd0) begin errors++; $display("[TB] FAIL rmb_state: got %0d expected 0", bus.sched_state); end
        late_writes = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus.out_write) late_writes++;
        end
        checks++; if (late_writes !== 0) begin errors++; $display("[TB] FAIL rmb_flushed: got %0d writes expected 0", late_writes); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        model_clear = 1'b1;
        push_en     = 1'b0;
        test_reset();
        test_single_queue_burst();
        test_round_robin();
        test_burst_zero();
        test_single_entry();
        test_backpressure();
        test_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
